// File: rtl/wd_mux_n_1_if.sv
// wd_mux_n_1 bus bundle: AW grant push, N master W channels, one slave W port.
// slave = mux side, master = driver side; WD_MUX_BURST_LEN_EN adds grant_len/wlast_err.
interface wd_mux_n_1_if #(
  parameter int NUM_M     = 4,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int GNT_DEPTH = 4,
  parameter int IDX_W     = $clog2(NUM_M)
);
  localparam int CNT_W = $clog2(GNT_DEPTH) + 1;

  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_master;
  logic                     grant_ready;
  logic [NUM_M*DATA_W-1:0]  S_AXI_wdata;
  logic [NUM_M*STRB_W-1:0]  S_AXI_wstrb;
  logic [NUM_M-1:0]         S_AXI_wlast;
  logic [NUM_M-1:0]         S_AXI_wvalid;
  logic [NUM_M-1:0]         S_AXI_wready;
  logic [DATA_W-1:0]        M_AXI_wdata;
  logic [STRB_W-1:0]        M_AXI_wstrb;
  logic                     M_AXI_wlast;
  logic                     M_AXI_wvalid;
  logic                     M_AXI_wready;
  logic [CNT_W-1:0]         gnt_count;
`ifdef WD_MUX_BURST_LEN_EN
  logic [7:0]               grant_len;
  logic                     wlast_err;
`endif

  modport slave (
`ifdef WD_MUX_BURST_LEN_EN
    input  grant_len,
    output wlast_err,
`endif
    input  grant_valid, grant_master,
    input  S_AXI_wdata, S_AXI_wstrb,
    input  S_AXI_wlast, S_AXI_wvalid,
    input  M_AXI_wready,
    output grant_ready, S_AXI_wready,
    output M_AXI_wdata, M_AXI_wstrb,
    output M_AXI_wlast, M_AXI_wvalid,
    output gnt_count
  );

  modport master (
`ifdef WD_MUX_BURST_LEN_EN
    output grant_len,
    input  wlast_err,
`endif
    output grant_valid, grant_master,
    output S_AXI_wdata, S_AXI_wstrb,
    output S_AXI_wlast, S_AXI_wvalid,
    output M_AXI_wready,
    input  grant_ready, S_AXI_wready,
    input  M_AXI_wdata, M_AXI_wstrb,
    input  M_AXI_wlast, M_AXI_wvalid,
    input  gnt_count
  );
endinterface

// File: rtl/wd_mux_n_1.sv
// N:1 AXI4 W mux: in-order grant FIFO picks the head master, one-entry output slice.
// Ports: ACLK, ARESETN (async low), bus (wd_mux_n_1_if.slave). Option: WD_MUX_BURST_LEN_EN.
module wd_mux_n_1 #(
  parameter int NUM_M     = 4,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int GNT_DEPTH = 4,
  parameter int IDX_W     = $clog2(NUM_M)
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  wd_mux_n_1_if.slave bus
);
  localparam int PTR_W = $clog2(GNT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  gm_q [GNT_DEPTH];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              wlast_q, wvalid_q;

  logic [IDX_W-1:0]  head;
  logic              grant_ready, push, pop;
  logic              load, accept, out_last;
  logic [NUM_M-1:0]  wready;
  logic [DATA_W-1:0] sel_data;
  logic [STRB_W-1:0] sel_strb;
  logic              sel_last, sel_valid;
`ifdef WD_MUX_BURST_LEN_EN
  logic [7:0]        len_q [GNT_DEPTH];
  logic [7:0]        bcnt_q;
  logic              cnt_last, err_q;
`endif

  always_comb begin
    head        = gm_q[rp_q];
    grant_ready = (cnt_q < CNT_W'(GNT_DEPTH)) && ARESETN;
    push        = bus.grant_valid && grant_ready;
    load        = !wvalid_q || bus.M_AXI_wready;
    sel_data    = '0;
    sel_strb    = '0;
    sel_last    = 1'b0;
    sel_valid   = 1'b0;
    wready      = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (IDX_W'(i) == head) begin
        sel_data  = bus.S_AXI_wdata[i*DATA_W +: DATA_W];
        sel_strb  = bus.S_AXI_wstrb[i*STRB_W +: STRB_W];
        sel_last  = bus.S_AXI_wlast[i];
        sel_valid = bus.S_AXI_wvalid[i];
        wready[i] = (cnt_q != '0) && load;
      end
    end
    accept = sel_valid && (|wready);
`ifdef WD_MUX_BURST_LEN_EN
    // burst end comes from the AWLEN count, not the master
    cnt_last = (bcnt_q == len_q[rp_q]);
    out_last = cnt_last;
`else
    out_last = sel_last;
`endif
    pop   = accept && out_last;
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // grant storage needs no reset: occupancy gates every read
  always_ff @(posedge ACLK) begin
    if (push) begin
      gm_q[wp_q] <= bus.grant_master;
`ifdef WD_MUX_BURST_LEN_EN
      len_q[wp_q] <= bus.grant_len;
`endif
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + PTR_W'(1);
      if (pop)  rp_q <= rp_q + PTR_W'(1);
      if (load) begin
        wvalid_q <= accept;
        if (accept) begin
          wdata_q <= sel_data;
          wstrb_q <= sel_strb;
          wlast_q <= out_last;
        end
      end
    end
  end

`ifdef WD_MUX_BURST_LEN_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bcnt_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      bcnt_q <= cnt_last ? 8'd0 : bcnt_q + 8'd1;
      if (sel_last != cnt_last) err_q <= 1'b1;
    end
  end

  assign bus.wlast_err = err_q;
`endif

  assign bus.grant_ready  = grant_ready;
  assign bus.gnt_count    = cnt_q;
  assign bus.S_AXI_wready = wready;
  assign bus.M_AXI_wdata  = wdata_q;
  assign bus.M_AXI_wstrb  = wstrb_q;
  assign bus.M_AXI_wlast  = wlast_q;
  assign bus.M_AXI_wvalid = wvalid_q;
endmodule

// File: tb/tb_wd_mux_n_1.sv
// Bench for wd_mux_n_1: directed scenarios plus random bursts,
// checked against a grant-order scoreboard of burst beats.
module tb_wd_mux_n_1;
  localparam int NM = 4;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int GD = 4;
  localparam int IW = 2;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  wd_mux_n_1_if #(
    .NUM_M(NM), .DATA_W(DW), .STRB_W(SW),
    .GNT_DEPTH(GD), .IDX_W(IW)
  ) bus ();

  wd_mux_n_1 #(
    .NUM_M(NM), .DATA_W(DW), .STRB_W(SW),
    .GNT_DEPTH(GD), .IDX_W(IW)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // beat = {last, strb, data}
  logic [36:0] beats[$];
  int          bur_m[$], bur_first[$], bur_len[$];
  logic [36:0] mq[NM][$];
  int          gtodo[$];
  int          hq[$], hlen[$];
  int          hb = 0;
  logic [36:0] expq[$];
  logic        mv[NM];
  logic        gv = 1'b0;
  logic        err_m = 1'b0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [36:0] pout = '0;
  int gprob = 100, wprob = 100, rprob = 100;

  task automatic add_burst(int m, int len, logic [31:0] base,
                           bit rnd, int bad_last = -1);
    logic [36:0] b;
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    bur_m.push_back(m);
    bur_first.push_back(beats.size());
    bur_len.push_back(len);
    for (int j = 0; j < len; j++) begin
      d = rnd ? $urandom : base + j;
      s = rnd ? 4'($urandom_range(15)) : 4'hF;
      l = (bad_last < 0) ? (j == len - 1) : (j == bad_last);
      b = {l, s, d};
      beats.push_back(b);
      mq[m].push_back(b);
    end
    gtodo.push_back(bur_m.size() - 1);
  endtask

  task automatic cycle();
    logic [NM-1:0] ewr;
    logic [36:0]   o, b;
    logic          lc, done;
    int            k;
    @(negedge ACLK);
    if (!gv && gtodo.size() > 0 && $urandom_range(99) < gprob)
      gv = 1'b1;
    bus.grant_valid  = gv;
    bus.grant_master = gv ? IW'(bur_m[gtodo[0]]) : '0;
`ifdef WD_MUX_BURST_LEN_EN
    bus.grant_len = gv ? 8'(bur_len[gtodo[0]] - 1) : 8'd0;
`endif
    for (int i = 0; i < NM; i++) begin
      if (!mv[i] && mq[i].size() > 0 && $urandom_range(99) < wprob)
        mv[i] = 1'b1;
      b = mq[i].size() > 0 ? mq[i][0] : '0;
      bus.S_AXI_wvalid[i]        = mv[i];
      bus.S_AXI_wdata[i*DW +: DW] = b[31:0];
      bus.S_AXI_wstrb[i*SW +: SW] = b[35:32];
      bus.S_AXI_wlast[i]         = b[36];
    end
    bus.M_AXI_wready = ($urandom_range(99) < rprob);
    #1;
    chk("gnt_count", bus.gnt_count, hq.size());
    chk("grant_ready", bus.grant_ready, hq.size() < GD);
    ewr = '0;
    if (hq.size() > 0 && (!bus.M_AXI_wvalid || bus.M_AXI_wready))
      ewr[hq[0]] = 1'b1;
    chk("s_wready", bus.S_AXI_wready, ewr);
    o = {bus.M_AXI_wlast, bus.M_AXI_wstrb, bus.M_AXI_wdata};
    if (pv && !pr)
      chk("slice_hold", {bus.M_AXI_wvalid, o}, {1'b1, pout});
`ifdef WD_MUX_BURST_LEN_EN
    chk("wlast_err", bus.wlast_err, err_m);
`endif
    if (bus.M_AXI_wvalid && bus.M_AXI_wready) begin
      if (expq.size() == 0)
        chk("spurious_beat", bus.M_AXI_wvalid, 1'b0);
      else
        chk("out_beat", o, expq.pop_front());
    end
    pv = bus.M_AXI_wvalid;
    pr = bus.M_AXI_wready;
    pout = o;
    for (int i = 0; i < NM; i++) begin
      if (mv[i] && bus.S_AXI_wready[i] && hq.size() > 0) begin
        b = mq[i].pop_front();
        mv[i] = 1'b0;
        lc = (hb == hlen[0] - 1);
`ifdef WD_MUX_BURST_LEN_EN
        if (b[36] != lc) err_m = 1'b1;
        done = lc;
`else
        done = b[36];
`endif
        if (done) begin
          void'(hq.pop_front());
          void'(hlen.pop_front());
          hb = 0;
        end else begin
          hb++;
        end
      end
    end
    if (gv && bus.grant_ready) begin
      k = gtodo.pop_front();
      hq.push_back(bur_m[k]);
      hlen.push_back(bur_len[k]);
      for (int j = 0; j < bur_len[k]; j++) begin
        b = beats[bur_first[k] + j];
`ifdef WD_MUX_BURST_LEN_EN
        b[36] = (j == bur_len[k] - 1);
`endif
        expq.push_back(b);
      end
      gv = 1'b0;
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((expq.size() > 0 || gtodo.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", expq.size() + gtodo.size(), 0);
  endtask

  task automatic rst_chk(string t);
    chk({t, "_wvalid"}, bus.M_AXI_wvalid, 1'b0);
    chk({t, "_wdata"}, bus.M_AXI_wdata, 32'h0);
    chk({t, "_wstrb"}, bus.M_AXI_wstrb, 4'h0);
    chk({t, "_wlast"}, bus.M_AXI_wlast, 1'b0);
    chk({t, "_s_wready"}, bus.S_AXI_wready, 4'h0);
    chk({t, "_gnt_count"}, bus.gnt_count, 3'd0);
    chk({t, "_grant_ready"}, bus.grant_ready, 1'b0);
  endtask

  task automatic model_clear();
    hq.delete();
    hlen.delete();
    expq.delete();
    gtodo.delete();
    hb = 0;
    gv = 1'b0;
    err_m = 1'b0;
    pv = 1'b0;
    bus.grant_valid = 1'b0;
  endtask

  initial begin
    int n;
    bus.grant_valid  = 1'b0;
    bus.grant_master = '0;
    bus.S_AXI_wdata  = '0;
    bus.S_AXI_wstrb  = '0;
    bus.S_AXI_wlast  = '0;
    bus.S_AXI_wvalid = '0;
    bus.M_AXI_wready = 1'b0;
`ifdef WD_MUX_BURST_LEN_EN
    bus.grant_len = 8'd0;
`endif
    for (int i = 0; i < NM; i++) mv[i] = 1'b0;

    repeat (2) @(negedge ACLK);
    #1 rst_chk("rst");
    @(negedge ACLK);
    ARESETN = 1'b1;

    // single 4-beat burst from master 2
    add_burst(2, 4, 32'h1000_0000, 0);
    drain(40);

    // three single-beat bursts, all masters waiting
    add_burst(0, 1, 32'hAAAA_0000, 0);
    add_burst(3, 1, 32'hAAAA_0003, 0);
    add_burst(1, 1, 32'hAAAA_0001, 0);
    drain(40);

    // fill the grant FIFO with no W traffic
    wprob = 0;
    for (int i = 0; i < 5; i++) add_burst(i % NM, 2, 32'h5000_0000 + (i << 8), 0);
    repeat (8) cycle();
    chk("full_count", bus.gnt_count, 3'd4);
    chk("full_ready", bus.grant_ready, 1'b0);
    wprob = 100;
    drain(60);

    // slave backpressure with a beat held in the slice
    rprob = 0;
    add_burst(1, 1, 32'hDEAD_BEEF, 0);
    n = 0;
    while (!bus.M_AXI_wvalid && n < 10) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk("stall_data", bus.M_AXI_wdata, 32'hDEAD_BEEF);
    rprob = 100;
    drain(20);

    // reset after beat 2 of 4
    add_burst(2, 4, 32'h2000_0000, 0);
    n = 0;
    while (mq[2].size() > 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("pre_rst_beats_left", mq[2].size(), 2);
    @(negedge ACLK);
    ARESETN = 1'b0;
    model_clear();
    #1 rst_chk("midrst");
    @(negedge ACLK);
    ARESETN = 1'b1;
    mv[2] = 1'b1;
    repeat (4) cycle();
    mq[2].delete();
    mv[2] = 1'b0;
    bus.S_AXI_wvalid = '0;

`ifdef WD_MUX_BURST_LEN_EN
    // master wlast early on a 2-beat burst
    add_burst(0, 2, 32'h3000_0000, 0, 0);
    drain(20);
    chk("err_sticky", bus.wlast_err, 1'b1);
`endif

    // random traffic
    gprob = 60;
    wprob = 70;
    rprob = 70;
    for (int i = 0; i < 60; i++)
      add_burst($urandom_range(NM - 1), $urandom_range(4, 1), 32'h0, 1);
    drain(3000);
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
